if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage RV32I core with exceptions and interrupts. It owns the fetch PC and drives the synchronous IROM address. It hands `{pc4, pc, int_flag}` to ID through the valid/allow-in handshake. It applies branch and trap redirects, and tags fetched instructions with a pending-interrupt flag so CLINT can take the interrupt at a precise PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `IROM_AW`, default 12: IROM word-address width; `irom_addr = pc[IROM_AW+1:2]`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `br_taken`  in  1  EX branch/jump redirect.
- `br_target`  in  32  redirect PC, word aligned.
- `int_assert`  in  1  CLINT trap/mret redirect.
- `int_addr`  in  32  trap vector or mepc.
- `irq_pending`  in  1  level: enabled interrupt pending (from CLINT/CSR).
- `hold_flag_if`  in  1  controller hold.
- `id_allow_in`  in  1  ID can accept.
- `if_to_id_valid`  out  1  bus valid.
- `if_to_id_bus`  out  `IF_TO_ID_BUS_WIDTH` (65)  `{pc4[31:0], pc[31:0], int_flag}`.
- `irom_addr`  out  `IROM_AW`  IROM read address.

## Operation
State registers:
- `fetch_pc`: PC currently offered to ID.
- `id_pc`: PC last accepted by ID.
- `if_valid`.
- Tag FSM.

Handshake and PC update:
- Transfer occurs when `if_to_id_valid && id_allow_in`. On transfer, `id_pc <= fetch_pc`.
- `if_to_id_valid = if_valid & ~hold_flag_if & ~br_taken & ~int_assert`.
- `pc4 = fetch_pc + 32'd4`, wrapping modulo 2^32. `pc = fetch_pc`.
- Next-PC priority: `int_assert` → `int_addr`; else `br_taken` → `br_target`; else transfer → `pc4`; else hold.

IROM addressing (IROM output arrives one cycle after the address and is consumed by ID together with the latched bus):
- `irom_addr` = `fetch_pc` when `id_allow_in`, else `id_pc`.
- Re-addressing with `id_pc` during an ID stall keeps the instruction stable.
- Bits [1:0] of the PC are ignored.

Tag FSM:
- IDLE: `int_flag = irq_pending`. A transfer with `int_flag=1` goes to ARMED.
- ARMED: `int_flag = 0` for all later fetches.
  - `int_assert` → IDLE (interrupt taken).
  - `br_taken` → IDLE (tagged instruction squashed; re-tag at the target if still pending).
- Both redirects in the same cycle: IDLE, `int_addr` wins.

## Timing
- Reset values: `fetch_pc = id_pc = RESET_PC`, `if_valid = 0`, FSM IDLE.
- Outputs during reset: `if_to_id_valid = 0`, `irom_addr = RESET_PC[IROM_AW+1:2]`, bus `{RESET_PC+4, RESET_PC, 0}` (`int_flag = 0` regardless of `irq_pending`).
- `if_valid` rises the first cycle after `rst_n` deasserts. First transfer is at `RESET_PC` in that cycle if `id_allow_in`.
- Throughput: one PC per cycle with no stalls.
- Redirect: cycle *t* has the redirect asserted with bus invalid; `fetch_pc` = target at *t*+1 and is offered valid at *t*+1. That is one bubble.
- `hold_flag_if` only gates valid and update. `fetch_pc` and the FSM are frozen.
- Reset asserted mid-stall or while ARMED returns everything to reset values on the next edge.

## Configuration
- `IF_IRQ_TAG_EN` defined: tag FSM is present as above.
- Undefined: FSM removed, `irq_pending` unused, `int_flag` constant 0. CLINT then takes interrupts only on ID-reported exception boundaries.

## Structure
- `defines.v` holds:
  - `IF_TO_ID_BUS_WIDTH` (65)
  - default reset vector
  - FSM encodings `IF_TAG_IDLE`/`IF_TAG_ARMED`
- One sub-module, `if_irq_tagger`, contains the FSM, the `int_flag` output and the transfer/redirect inputs. Compile it only under `IF_IRQ_TAG_EN`.
- PC logic stays inline.

## Test plan
- Reset release, `id_allow_in=1`: PCs offered 0x0, 0x4, 0x8 on consecutive cycles; `irom_addr` 0, 1, 2; valid low during reset.
- ID stall at PC 0x8 for 3 cycles: `irom_addr` stays 1 (`id_pc` 0x4); `fetch_pc` holds 0x8; 0x8 transfers when allow-in returns.
- `br_taken` with target 0x100 at PC 0xC: valid low that cycle; next cycle 0x100 offered with `pc4` 0x104.
- `br_taken` and `int_assert` same cycle, `int_addr` 0x80, `br_target` 0x200: next PC 0x80, FSM IDLE.
- With `IF_IRQ_TAG_EN`, `irq_pending=1` from PC 0x10:
  - 0x10 tagged; 0x14, 0x18 untagged.
  - `int_assert` → vector fetched tagged only if `irq_pending` is still 1.
  - A `br_taken` while ARMED re-tags the first instruction at the target.
- Without the macro: `irq_pending=1` never sets `int_flag`.

Source files
------------

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared constants and tag FSM encodings for the IF stage.
package if_stage_pkg;
  localparam int IF_TO_ID_BUS_WIDTH = 65;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic {IF_TAG_IDLE = 1'b0, IF_TAG_ARMED = 1'b1} if_tag_e;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: redirect, handshake and IROM address signals of the IF stage.
interface if_stage_if #(parameter int IROM_AW = 12);
  import if_stage_pkg::*;
  logic br_taken;
  logic [31:0] br_target;
  logic int_assert;
  logic [31:0] int_addr;
  logic irq_pending;
  logic hold_flag_if;
  logic id_allow_in;
  logic if_to_id_valid;
  logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus;
  logic [IROM_AW-1:0] irom_addr;
  modport master (
    input br_taken, br_target, int_assert, int_addr, irq_pending, hold_flag_if, id_allow_in,
    output if_to_id_valid, if_to_id_bus, irom_addr
  );
  modport slave (
    output br_taken, br_target, int_assert, int_addr, irq_pending, hold_flag_if, id_allow_in,
    input if_to_id_valid, if_to_id_bus, irom_addr
  );
endinterface

// File: rtl/if_irq_tagger.sv
// if_irq_tagger: marks one fetched instruction per pending interrupt so CLINT traps at a precise PC.
// Built only when IF_IRQ_TAG_EN is defined.
`ifdef IF_IRQ_TAG_EN
module if_irq_tagger
  import if_stage_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic irq_pending,
  input  logic hold,
  input  logic xfer,
  input  logic br_taken,
  input  logic int_assert,
  output logic int_flag
);
  if_tag_e state_q, state_d;
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IF_TAG_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = hold ? state_q
            : (int_assert | br_taken) ? IF_TAG_IDLE
            : (state_q == IF_TAG_IDLE && xfer && irq_pending) ? IF_TAG_ARMED
            : state_q;
  end
  always_comb begin
    int_flag = rst_n & (state_q == IF_TAG_IDLE) & irq_pending;
  end
endmodule
`endif

// File: rtl/if_stage.sv
// if_stage: fetch PC, IROM addressing and IF->ID handshake of the RV32I pipeline.
// Define IF_IRQ_TAG_EN to tag fetched instructions with a pending-interrupt flag.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int IROM_AW = 12
) (
  input logic clk,
  input logic rst_n,
  if_stage_if.master bus
);
  logic [31:0] fetch_pc_q, fetch_pc_d, id_pc_q, id_pc_d, addr_pc;
  logic if_valid_q, valid, xfer, int_flag;
  assign valid = rst_n & if_valid_q & ~bus.hold_flag_if & ~bus.br_taken & ~bus.int_assert;
  assign xfer = valid & bus.id_allow_in;
  always_comb begin
    fetch_pc_d = bus.hold_flag_if ? fetch_pc_q
               : bus.int_assert ? bus.int_addr
               : bus.br_taken ? bus.br_target
               : xfer ? fetch_pc_q + 32'd4
               : fetch_pc_q;
    id_pc_d = xfer ? fetch_pc_q : id_pc_q;
    // re-issue the last accepted PC while ID stalls so the IROM output stays put
    addr_pc = bus.id_allow_in ? fetch_pc_q : id_pc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      id_pc_q <= RESET_PC;
      if_valid_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      id_pc_q <= id_pc_d;
      if_valid_q <= 1'b1;
    end
  end
`ifdef IF_IRQ_TAG_EN
  if_irq_tagger u_tagger (
    .clk(clk),
    .rst_n(rst_n),
    .irq_pending(bus.irq_pending),
    .hold(bus.hold_flag_if),
    .xfer(xfer),
    .br_taken(bus.br_taken),
    .int_assert(bus.int_assert),
    .int_flag(int_flag)
  );
`else
  logic unused_irq;
  assign unused_irq = bus.irq_pending;
  assign int_flag = 1'b0;
`endif
  assign bus.if_to_id_valid = valid;
  assign bus.if_to_id_bus = {fetch_pc_q + 32'd4, fetch_pc_q, int_flag};
  assign bus.irom_addr = addr_pc[IROM_AW+1:2];
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of fetch order, stalls, redirects, tagging and reset.
module tb_if_stage;
  import if_stage_pkg::*;
`ifdef IF_IRQ_TAG_EN
  localparam logic TAG = 1'b1;
`else
  localparam logic TAG = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  int errors = 0;
  int checks = 0;
  if_stage_if #(.IROM_AW(12)) bus ();
  if_stage #(.RESET_PC(32'h0), .IROM_AW(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic vld, input logic [31:0] pc, input logic flag,
                      input logic [11:0] irom);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    #1;
    chk({tag, "_valid"}, 65'(bus.if_to_id_valid), 65'(vld));
    chk({tag, "_bus"}, bus.if_to_id_bus, {p4, pc, flag});
    chk({tag, "_irom"}, 65'(bus.irom_addr), 65'(irom));
    @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = 32'h0;
    bus.int_assert = 1'b0;
    bus.int_addr = 32'h0;
    bus.irq_pending = 1'b1;
    bus.hold_flag_if = 1'b0;
    bus.id_allow_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    step("reset", 0, 32'h0, 0, 12'h0);
    rst_n = 1'b1; bus.irq_pending = 1'b0;
    step("release", 0, 32'h0, 0, 12'h0);
    step("pc0", 1, 32'h0, 0, 12'h0);
    step("pc4", 1, 32'h4, 0, 12'h1);
    bus.id_allow_in = 1'b0;
    step("stall1", 1, 32'h8, 0, 12'h1);
    step("stall2", 1, 32'h8, 0, 12'h1);
    step("stall3", 1, 32'h8, 0, 12'h1);
    bus.id_allow_in = 1'b1;
    step("pc8", 1, 32'h8, 0, 12'h2);
    bus.br_taken = 1'b1; bus.br_target = 32'h100;
    step("br", 0, 32'hC, 0, 12'h3);
    bus.br_taken = 1'b0;
    step("br_tgt", 1, 32'h100, 0, 12'h40);
    bus.br_taken = 1'b1; bus.br_target = 32'h200; bus.int_assert = 1'b1; bus.int_addr = 32'h80;
    step("both", 0, 32'h104, 0, 12'h41);
    bus.br_taken = 1'b0; bus.int_assert = 1'b0;
    step("both_tgt", 1, 32'h80, 0, 12'h20);
    bus.br_taken = 1'b1; bus.br_target = 32'h10;
    step("br10", 0, 32'h84, 0, 12'h21);
    bus.br_taken = 1'b0; bus.irq_pending = 1'b1;
    step("tag10", 1, 32'h10, TAG, 12'h4);
    step("tag14", 1, 32'h14, 0, 12'h5);
    step("tag18", 1, 32'h18, 0, 12'h6);
    bus.int_assert = 1'b1; bus.int_addr = 32'h40;
    step("trap", 0, 32'h1C, 0, 12'h7);
    bus.int_assert = 1'b0;
    step("vec_tag", 1, 32'h40, TAG, 12'h10);
    bus.br_taken = 1'b1; bus.br_target = 32'h300;
    step("br_armed", 0, 32'h44, 0, 12'h11);
    bus.br_taken = 1'b0;
    step("retag", 1, 32'h300, TAG, 12'hC0);
    bus.int_assert = 1'b1; bus.int_addr = 32'h40; bus.irq_pending = 1'b0;
    step("trap2", 0, 32'h304, 0, 12'hC1);
    bus.int_assert = 1'b0;
    step("vec_notag", 1, 32'h40, 0, 12'h10);
    bus.hold_flag_if = 1'b1;
    step("hold", 0, 32'h44, 0, 12'h11);
    bus.hold_flag_if = 1'b0;
    step("unhold", 1, 32'h44, 0, 12'h11);
    bus.irq_pending = 1'b1;
    step("tag48", 1, 32'h48, TAG, 12'h12);
    bus.hold_flag_if = 1'b1;
    step("hold_armed", 0, 32'h4C, 0, 12'h13);
    bus.hold_flag_if = 1'b0;
    step("still_armed", 1, 32'h4C, 0, 12'h13);
    bus.br_taken = 1'b1; bus.br_target = 32'hFFFF_FFFC;
    step("br_wrap", 0, 32'h50, 0, 12'h14);
    bus.br_taken = 1'b0; bus.irq_pending = 1'b0;
    step("wrap_top", 1, 32'hFFFF_FFFC, 0, 12'hFFF);
    step("wrap_zero", 1, 32'h0, 0, 12'h0);
    bus.irq_pending = 1'b1;
    step("arm4", 1, 32'h4, TAG, 12'h1);
    bus.id_allow_in = 1'b0;
    step("stall8", 1, 32'h8, 0, 12'h1);
    rst_n = 1'b0;
    step("rst_assert", 0, 32'h8, 0, 12'h1);
    step("rst_held", 0, 32'h0, 0, 12'h0);
    rst_n = 1'b1; bus.id_allow_in = 1'b1;
    step("rst_rel", 0, 32'h0, TAG, 12'h0);
    step("rst_pc0", 1, 32'h0, TAG, 12'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
